// File: rtl/bp_cfg_pkg.sv
// Shared types and config-bus register map for the BlackParrot boot-time
// configuration sequencer.
package bp_cfg_pkg;

  localparam logic [15:0] bp_cfg_freeze_addr_gp     = 16'h0002;
  localparam logic [15:0] bp_cfg_core_id_addr_gp    = 16'h0004;
  localparam logic [15:0] bp_cfg_cce_mode_addr_gp   = 16'h0008;
  localparam logic [15:0] bp_cfg_ucode_base_addr_gp = 16'h8000;

  typedef enum logic [3:0] {
    e_idle,
    e_freeze,
    e_core_id,
    e_uc_rd,
    e_uc_wr,
    e_mode,
    e_unfreeze,
    e_next,
    e_done
  } bp_cfg_state_e;

  // Widest supported core/addr/data fields; the top resizes to its parameters.
  typedef struct packed {
    logic [7:0]  core;
    logic [15:0] addr;
    logic [31:0] data;
  } bp_cfg_write_s;

endpackage

// File: rtl/bp_cfg_write_reg.sv
// Valid/ready output register for config writes: once loaded, the payload is
// held unchanged until the sink accepts it.
module bp_cfg_write_reg
  import bp_cfg_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          load_i,
  input  bp_cfg_write_s load_data_i,
  input  logic          ready_i,
  output logic          v_o,
  output bp_cfg_write_s data_o
);

  // Handshake: a write transfers on any cycle with v_o & ready_i; while v_o is
  // high and ready_i low, v_o and data_o hold. The owner loads only when the
  // register is empty or its current write is being accepted.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o    <= 1'b0;
      data_o <= '0;
    end else if (load_i) begin
      v_o    <= 1'b1;
      data_o <= load_data_i;
    end else if (v_o && ready_i) begin
      v_o    <= 1'b0;
    end
  end

  hold_stable_a: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (v_o && !ready_i) |=> (v_o && $stable(data_o)));

endmodule

// File: rtl/bp_cfg_boot_sequencer.sv
// Post-reset config controller: for each core issues freeze, core id, CCE
// microcode, CCE mode and unfreeze writes, then raises a sticky done_o.
module bp_cfg_boot_sequencer
  import bp_cfg_pkg::*;
#(
  parameter int num_core_p       = 2,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 32,
  parameter int cce_pc_width_p   = 8,
  parameter int ucode_els_p      = 256,
  localparam int core_width_lp   = (num_core_p > 1) ? $clog2(num_core_p) : 1
)
(
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  input  logic                        cce_mode_i,
  output logic [cce_pc_width_p-1:0]   ucode_addr_o,
  input  logic [cfg_data_width_p-1:0] ucode_data_i,
  output logic                        cfg_v_o,
  output logic [core_width_lp-1:0]    cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i,
  output logic                        busy_o,
  output logic                        done_o,
  output bp_cfg_state_e               state_o
);

  bp_cfg_state_e              state_q;
  logic [core_width_lp-1:0]   core_cnt_q;
  logic [cce_pc_width_p-1:0]  uc_cnt_q;
  logic                       mode_q;

  logic                       accept;
  logic                       uc_last;
  logic                       core_last;
  logic [core_width_lp-1:0]   core_nxt;
  logic [cce_pc_width_p-1:0]  uc_nxt;

  logic                       wr_load;
  bp_cfg_write_s              wr_next;
  bp_cfg_write_s              wr_q;
  logic                       unused_bits;

  assign accept    = cfg_v_o & cfg_ready_i;
  assign uc_last   = (uc_cnt_q == cce_pc_width_p'(ucode_els_p - 1));
  assign core_last = (core_cnt_q == core_width_lp'(num_core_p - 1));
  assign core_nxt  = core_cnt_q + core_width_lp'(1);
  assign uc_nxt    = uc_cnt_q + cce_pc_width_p'(1);
  assign state_o   = state_q;

  // The write register is loaded on the same edge that enters a write state,
  // so cfg_v_o rises together with the state and costs no extra cycle.
  always_comb begin
    wr_load      = 1'b0;
    wr_next      = '0;
    wr_next.core = 8'(core_cnt_q);
    case (state_q)
      e_idle: if (start_i) begin
        wr_load      = 1'b1;
        wr_next.core = '0;
        wr_next.addr = bp_cfg_freeze_addr_gp;
        wr_next.data = 32'd1;
      end
      e_freeze: if (accept) begin
        wr_load      = 1'b1;
        wr_next.addr = bp_cfg_core_id_addr_gp;
        wr_next.data = 32'(core_cnt_q);
      end
      e_uc_rd: begin
        wr_load      = 1'b1;
        wr_next.addr = bp_cfg_ucode_base_addr_gp + 16'(uc_cnt_q);
        wr_next.data = 32'(ucode_data_i);
      end
      e_uc_wr: if (accept && uc_last) begin
        wr_load      = 1'b1;
        wr_next.addr = bp_cfg_cce_mode_addr_gp;
        wr_next.data = 32'(mode_q);
      end
      e_mode: if (accept) begin
        wr_load      = 1'b1;
        wr_next.addr = bp_cfg_freeze_addr_gp;
        wr_next.data = 32'd0;
      end
      e_next: if (!core_last) begin
        wr_load      = 1'b1;
        wr_next.core = 8'(core_nxt);
        wr_next.addr = bp_cfg_freeze_addr_gp;
        wr_next.data = 32'd1;
      end
      default: ;
    endcase
  end

  // ucode_addr_o runs one word ahead: it is set while the previous word is
  // being written so the ROM data is already present during UC_RD.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= e_idle;
      core_cnt_q   <= '0;
      uc_cnt_q     <= '0;
      mode_q       <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      ucode_addr_o <= '0;
    end else begin
      case (state_q)
        e_idle: if (start_i) begin
          state_q      <= e_freeze;
          core_cnt_q   <= '0;
          uc_cnt_q     <= '0;
          ucode_addr_o <= '0;
          mode_q       <= cce_mode_i;
          busy_o       <= 1'b1;
        end
        e_freeze:   if (accept) state_q <= e_core_id;
        e_core_id:  if (accept) state_q <= e_uc_rd;
        e_uc_rd: begin
          state_q      <= e_uc_wr;
          ucode_addr_o <= uc_last ? '0 : uc_nxt;
        end
        e_uc_wr: if (accept) begin
          if (uc_last) begin
            uc_cnt_q <= '0;
            state_q  <= e_mode;
          end else begin
            uc_cnt_q <= uc_nxt;
            state_q  <= e_uc_rd;
          end
        end
        e_mode:     if (accept) state_q <= e_unfreeze;
        e_unfreeze: if (accept) state_q <= e_next;
        e_next: begin
          if (core_last) begin
            state_q <= e_done;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
          end else begin
            core_cnt_q <= core_nxt;
            state_q    <= e_freeze;
          end
        end
        e_done:  ;
        default: state_q <= e_idle;
      endcase
    end
  end

  bp_cfg_write_reg u_write_reg (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .load_i      (wr_load),
    .load_data_i (wr_next),
    .ready_i     (cfg_ready_i),
    .v_o         (cfg_v_o),
    .data_o      (wr_q)
  );

  assign cfg_core_o = core_width_lp'(wr_q.core);
  assign cfg_addr_o = cfg_addr_width_p'(wr_q.addr);
  assign cfg_data_o = cfg_data_width_p'(wr_q.data);

  // Collects struct and ROM bits that narrower parameterisations leave unused.
  assign unused_bits = ^{wr_q, ucode_data_i};

endmodule
